// File: rtl/aes_pkg.sv
// Shared definitions for the AES core arbiter: key-size modes, arbiter states
// and the expected done index for each mode.
package aes_pkg;

  localparam logic [1:0] AES128   = 2'b00;
  localparam logic [1:0] AES192   = 2'b01;
  localparam logic [1:0] AES256   = 2'b10;
  localparam logic [1:0] AES_RSVD = 2'b11;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} arb_state_e;

  // Busy-cycle index at which the core must raise done for a given key size.
  function automatic logic [CNT_W-1:0] done_index(input logic [1:0] mode);
    case (mode)
      AES128:  done_index = 4'd9;
      AES192:  done_index = 4'd11;
      default: done_index = 4'd13;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: searches from ptr+1 upward with wrap.
// The pointer register lives in the parent.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  always_comb begin
    logic        found;
    int unsigned j;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      j = (32'(ptr) + i) % N;
      if (enable && !found && req[j]) begin
        grant[j] = 1'b1;
        idx      = IW'(j);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_core_arbiter.sv
// Round-robin sharing of one AES round core among NUM_REQ requesters, with
// done-timing watchdog and valid/ready result return.
module aes_core_arbiter
  import aes_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned KEY_W   = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [2*NUM_REQ-1:0]      req_mode,
  input  logic [NUM_REQ-1:0]        req_enc_dec,
  input  logic [KEY_W*NUM_REQ-1:0]  req_key,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      core_rst,
  output logic                      core_start,
  output logic [1:0]                core_mode,
  output logic                      core_enc_dec,
  output logic [KEY_W-1:0]          core_key,
  output logic [DATA_W-1:0]         core_data,
  input  logic                      core_done,
  input  logic [DATA_W-1:0]         core_result
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       gidx_q, gidx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic                abort_q, abort_d;
  logic                core_start_q, core_start_d;
  logic [1:0]          core_mode_q, core_mode_d;
  logic                core_enc_dec_q, core_enc_dec_d;
  logic [KEY_W-1:0]    core_key_q, core_key_d;
  logic [DATA_W-1:0]   core_data_q, core_data_d;

  logic [NUM_REQ-1:0]  arb_grant;
  logic [IW-1:0]       arb_idx;
  logic [1:0]          sel_mode;
  logic [CNT_W-1:0]    exp_idx;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req    (req_valid),
    .ptr    (ptr_q),
    .enable (state_q == IDLE && !reset),
    .grant  (arb_grant),
    .idx    (arb_idx)
  );

  assign sel_mode = req_mode[2*arb_idx +: 2];
  assign exp_idx  = done_index(core_mode_q);

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    gidx_d         = gidx_q;
    cnt_d          = cnt_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_data_d     = rsp_data_q;
    rsp_err_d      = rsp_err_q;
    abort_d        = 1'b0;
    core_start_d   = 1'b0;
    core_mode_d    = core_mode_q;
    core_enc_dec_d = core_enc_dec_q;
    core_key_d     = core_key_q;
    core_data_d    = core_data_q;
    case (state_q)
      IDLE: begin
        if (|arb_grant) begin
          ptr_d          = arb_idx;
          gidx_d         = arb_idx;
          core_mode_d    = sel_mode;
          core_enc_dec_d = req_enc_dec[arb_idx];
          core_key_d     = req_key[KEY_W*arb_idx +: KEY_W];
          core_data_d    = req_data[DATA_W*arb_idx +: DATA_W];
          if (sel_mode == AES_RSVD) begin
            state_d     = RESP;
            rsp_valid_d = arb_grant;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end else begin
            state_d      = ISSUE;
            core_start_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // Done exactly on the expected index succeeds; early done or no done
        // by that index both abort the core.
        if (core_done || cnt_q == exp_idx) begin
          state_d             = RESP;
          rsp_valid_d         = '0;
          rsp_valid_d[gidx_q] = 1'b1;
          if (core_done && cnt_q == exp_idx) begin
            rsp_data_d = core_result;
            rsp_err_d  = 1'b0;
          end else begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            abort_d    = 1'b1;
          end
        end
      end
      RESP: begin
        if (rsp_ready[gidx_q]) begin
          state_d     = IDLE;
          rsp_valid_d = '0;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      ptr_q          <= IW'(NUM_REQ - 1);
      gidx_q         <= '0;
      cnt_q          <= '0;
      rsp_valid_q    <= '0;
      rsp_data_q     <= '0;
      rsp_err_q      <= 1'b0;
      abort_q        <= 1'b0;
      core_start_q   <= 1'b0;
      core_mode_q    <= '0;
      core_enc_dec_q <= 1'b0;
      core_key_q     <= '0;
      core_data_q    <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      gidx_q         <= gidx_d;
      cnt_q          <= cnt_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_err_q      <= rsp_err_d;
      abort_q        <= abort_d;
      core_start_q   <= core_start_d;
      core_mode_q    <= core_mode_d;
      core_enc_dec_q <= core_enc_dec_d;
      core_key_q     <= core_key_d;
      core_data_q    <= core_data_d;
    end
  end

  assign req_ready    = arb_grant;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;
  assign core_rst     = reset | abort_q;
  assign core_start   = core_start_q;
  assign core_mode    = core_mode_q;
  assign core_enc_dec = core_enc_dec_q;
  assign core_key     = core_key_q;
  assign core_data    = core_data_q;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter: rotation, latency per key size, early
// done, timeout with held response, reserved mode and mid-run reset.
module tb_aes_core_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 128;
  localparam int unsigned KW = 256;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid, req_ready, req_enc_dec;
  logic [2*N-1:0]    req_mode;
  logic [KW*N-1:0]   req_key;
  logic [DW*N-1:0]   req_data;
  logic [N-1:0]      rsp_valid, rsp_ready;
  logic [DW-1:0]     rsp_data, core_data, core_result;
  logic              rsp_err, core_rst, core_start, core_enc_dec, core_done;
  logic [1:0]        core_mode;
  logic [KW-1:0]     core_key;

  int tests = 0;
  int fails = 0;

  aes_core_arbiter #(.NUM_REQ(N), .DATA_W(DW), .KEY_W(KW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_enc_dec(req_enc_dec), .req_key(req_key), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .core_rst(core_rst), .core_start(core_start),
    .core_mode(core_mode), .core_enc_dec(core_enc_dec), .core_key(core_key),
    .core_data(core_data), .core_done(core_done), .core_result(core_result)
  );

  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [N-1:0] oh(input int g);
    logic [N-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  // Called in the grant cycle with inputs already driven; returns in the IDLE
  // cycle following the response handshake.
  task automatic do_op(input string tag, input int g, input logic [1:0] mode,
                       input int done_off, input int rsp_off, input logic exp_err,
                       input logic exp_abort, input logic [DW-1:0] result,
                       input int hold, input logic drop);
    logic [DW-1:0] exp_data;
    exp_data = exp_err ? '0 : result;
    #1;
    chk({tag, "_grant"}, req_ready, oh(g));
    for (int n = 1; n <= rsp_off; n++) begin
      cyc();
      if (n == 1 && drop) req_valid[g] = 1'b0;
      core_done   = (n == done_off);
      core_result = (n == done_off) ? result : {4{32'hdeadbeef}};
      #1;
      chk({tag, "_start"}, core_start, (n == 1 && mode != 2'b11));
      chk({tag, "_mode"}, core_mode, mode);
      chk({tag, "_rdy0"}, req_ready, '0);
      chk({tag, "_rvld"}, rsp_valid, (n == rsp_off) ? oh(g) : '0);
      if (n == 1) begin
        chk({tag, "_key"}, core_key, req_key[KW*g +: KW]);
        chk({tag, "_data"}, core_data, req_data[DW*g +: DW]);
        chk({tag, "_dir"}, core_enc_dec, req_enc_dec[g]);
      end
    end
    core_done = 1'b0;
    chk({tag, "_err"}, rsp_err, exp_err);
    chk({tag, "_rdata"}, rsp_data, exp_data);
    chk({tag, "_crst"}, core_rst, exp_abort);
    for (int h = 0; h < hold; h++) begin
      rsp_ready = ~oh(g);
      cyc();
      #1;
      chk({tag, "_hold_vld"}, rsp_valid, oh(g));
      chk({tag, "_hold_data"}, rsp_data, exp_data);
      chk({tag, "_hold_err"}, rsp_err, exp_err);
      chk({tag, "_hold_crst"}, core_rst, 1'b0);
      chk({tag, "_hold_mode"}, core_mode, mode);
    end
    rsp_ready = oh(g);
    cyc();
    rsp_ready = '0;
    #1;
    chk({tag, "_released"}, rsp_valid, '0);
    chk({tag, "_crst_end"}, core_rst, 1'b0);
  endtask

  initial begin
    reset       = 1'b1;
    req_valid   = '0;
    req_mode    = '0;
    req_enc_dec = 4'b1010;
    rsp_ready   = '0;
    core_done   = 1'b0;
    core_result = '0;
    for (int i = 0; i < N; i++) begin
      req_key[KW*i +: KW]  = {8{32'h1111_0000 + 32'(i)}};
      req_data[DW*i +: DW] = {4{32'hA5A5_0000 + 32'(i)}};
    end

    // Reset state
    cyc();
    cyc();
    #1;
    chk("rst_crst", core_rst, 1'b1);
    chk("rst_rvld", rsp_valid, '0);
    chk("rst_start", core_start, 1'b0);
    chk("rst_key", core_key, '0);
    chk("rst_rerr", rsp_err, 1'b0);
    reset = 1'b0;
    cyc();
    #1;
    chk("rel_crst", core_rst, 1'b0);

    // All requesters valid: rotation 0,1,2,3,0 with latencies 12/14/16/12/12
    req_mode  = 8'b00_10_01_00;
    req_valid = 4'b1111;
    do_op("rr0", 0, 2'b00, 11, 12, 1'b0, 1'b0, 128'h100, 0, 1'b0);
    do_op("rr1", 1, 2'b01, 13, 14, 1'b0, 1'b0, 128'h101, 0, 1'b0);
    do_op("rr2", 2, 2'b10, 15, 16, 1'b0, 1'b0, 128'h102, 0, 1'b0);
    do_op("rr3", 3, 2'b00, 11, 12, 1'b0, 1'b0, 128'h103, 0, 1'b0);
    do_op("rr4", 0, 2'b00, 11, 12, 1'b0, 1'b0, 128'h104, 0, 1'b1);
    req_valid = '0;

    // Single AES128 from requester 2
    req_mode     = 8'b00_00_00_00;
    req_valid[2] = 1'b1;
    do_op("single2", 2, 2'b00, 11, 12, 1'b0, 1'b0, 128'hCAFE_F00D_1234_5678, 0, 1'b1);

    // AES192 with early done at G+12
    req_mode     = 8'b01_00_00_00;
    req_valid[3] = 1'b1;
    do_op("early3", 3, 2'b01, 12, 13, 1'b1, 1'b1, 128'h77, 0, 1'b1);

    // Reserved mode from requester 1
    req_mode     = 8'b00_00_11_00;
    req_valid[1] = 1'b1;
    do_op("rsvd1", 1, 2'b11, 0, 1, 1'b1, 1'b0, 128'h0, 0, 1'b1);

    // AES256 timeout, response held 5 cycles
    req_mode     = 8'b00_00_00_10;
    req_valid[0] = 1'b1;
    do_op("tmo0", 0, 2'b10, 0, 16, 1'b1, 1'b1, 128'h0, 5, 1'b1);

    // Reset at G+6 of an AES256 run
    req_mode     = 8'b10_00_00_00;
    req_valid[3] = 1'b1;
    #1;
    chk("mrst_grant", req_ready, 4'b1000);
    for (int n = 1; n <= 6; n++) begin
      cyc();
      if (n == 1) req_valid[3] = 1'b0;
      if (n == 6) reset = 1'b1;
      #1;
      chk("mrst_rvld_run", rsp_valid, '0);
    end
    cyc();
    #1;
    chk("mrst_crst", core_rst, 1'b1);
    chk("mrst_mode", core_mode, 2'b00);
    chk("mrst_key", core_key, '0);
    chk("mrst_data", core_data, '0);
    chk("mrst_rvld", rsp_valid, '0);
    chk("mrst_start", core_start, 1'b0);
    reset = 1'b0;
    cyc();
    #1;
    chk("mrst_crst_rel", core_rst, 1'b0);
    chk("mrst_rvld_rel", rsp_valid, '0);
    req_valid = 4'b1001;
    #1;
    chk("mrst_first_grant", req_ready, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
